// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - single-port word memory answering bus requests after a fixed latency
//
// Purpose: accepts one read or write request at a time, waits LATENCY cycles,
// then performs the access and pulses a one-cycle completion strobe.
// Optional build macro: BUS_RESP_ADDR_CHECK_EN adds BUS_err and address range checks.
//
// Ports:
//   clk                    sole clock, rising edge
//   rst                    synchronous active-high reset
//   BUS_start_transaction  request strobe (ignored while busy)
//   BUS_mode               0 = read, 1 = write
//   BUS_addr[31:0]         byte address, word index is BUS_addr[ADDR_W+1:2]
//   BUS_wdata[31:0]        write data
//   BUS_rdata[31:0]        read data, holds its value outside the response cycle
//   BUS_rdata_valid        one-cycle read completion strobe
//   BUS_write_done         one-cycle write completion strobe
//   busy                   high whenever a request is in flight
//   BUS_err                (macro only) out-of-range flag, valid with the strobe
module bus_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BUS_start_transaction,
  input  logic        BUS_mode,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rdata_valid,
  output logic        BUS_write_done,
  output logic        busy
`ifdef BUS_RESP_ADDR_CHECK_EN
  ,
  output logic        BUS_err
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              oor_q, oor_d;
  logic              enter_resp;
  logic              mem_we;
  logic              req_oor;
  logic              unused_addr_bits;

  logic [31:0] mem [DEPTH];

`ifdef BUS_RESP_ADDR_CHECK_EN
  assign req_oor = |BUS_addr[31:ADDR_W+2];
`else
  // Upper bits are dropped, so addresses alias modulo the memory size.
  assign req_oor = 1'b0;
`endif
  assign unused_addr_bits = ^{BUS_addr[31:ADDR_W+2], BUS_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (BUS_start_transaction) begin
          mode_d  = BUS_mode;
          idx_d   = BUS_addr[ADDR_W+1:2];
          wdata_d = BUS_wdata;
          oor_d   = req_oor;
          if (LATENCY == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The access uses the *_d request fields so that a zero-latency request,
    // latched on the same edge that enters RESP, sees its own address/data.
    if (enter_resp && !mode_d) begin
      rdata_d = oor_d ? 32'd0 : mem[idx_d];
    end
  end

  assign mem_we = enter_resp && mode_d && !oor_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oor_q   <= oor_d;
    end
  end

  // Memory is never cleared; a reset edge blocks the write so an aborted
  // request leaves the old contents intact.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx_d] <= wdata_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign BUS_rdata       = rdata_q;
  assign BUS_rdata_valid = (state_q == S_RESP) && !mode_q;
  assign BUS_write_done  = (state_q == S_RESP) && mode_q;
`ifdef BUS_RESP_ADDR_CHECK_EN
  assign BUS_err         = (state_q == S_RESP) && oor_q;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - self-checking bench for bus_mem_responder at LATENCY 2 and 0
module tb_bus_mem_responder;

  localparam int AW = 8;

  logic        clk;
  logic        rst   [2];
  logic        start [2];
  logic        mode  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rvalid[2];
  logic        wdone [2];
  logic        busy  [2];
  logic        err   [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference memory: key = dut*4096 + word index.
  logic [31:0] mdl [int];

  bus_mem_responder #(.ADDR_W(AW), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .BUS_start_transaction(start[0]), .BUS_mode(mode[0]),
    .BUS_addr(addr[0]), .BUS_wdata(wdata[0]), .BUS_rdata(rdata[0]),
    .BUS_rdata_valid(rvalid[0]), .BUS_write_done(wdone[0]), .busy(busy[0])
`ifdef BUS_RESP_ADDR_CHECK_EN
    , .BUS_err(err[0])
`endif
  );

  bus_mem_responder #(.ADDR_W(AW), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst[1]), .BUS_start_transaction(start[1]), .BUS_mode(mode[1]),
    .BUS_addr(addr[1]), .BUS_wdata(wdata[1]), .BUS_rdata(rdata[1]),
    .BUS_rdata_valid(rvalid[1]), .BUS_write_done(wdone[1]), .busy(busy[1])
`ifdef BUS_RESP_ADDR_CHECK_EN
    , .BUS_err(err[1])
`endif
  );

`ifndef BUS_RESP_ADDR_CHECK_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit in_range(input logic [31:0] a);
`ifdef BUS_RESP_ADDR_CHECK_EN
    return (a >> (AW + 2)) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'((a / 4) % (1 << AW));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request starting in the current cycle (called just after a
  // rising edge) and check timing, strobe kind, error flag and data.
  task automatic txn(input int d, input bit m, input logic [31:0] a, input logic [31:0] wd,
                     input string tag, output logic [31:0] rd);
    bit          seen;
    bit          rng;
    bit          known;
    int          busy_low;
    int          k;
    logic [31:0] exp;
    rng      = in_range(a);
    k        = key(d, a);
    known    = !rng || mdl.exists(k);
    exp      = !rng ? 32'd0 : (mdl.exists(k) ? mdl[k] : 32'd0);
    seen     = 1'b0;
    busy_low = 0;
    rd       = 32'd0;
    start[d] = 1'b1; mode[d] = m; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    start[d] = 1'b0; mode[d] = $urandom; addr[d] = $urandom; wdata[d] = $urandom;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (rvalid[d] || wdone[d]) begin
        seen = 1'b1;
        chk({tag, "_latency"}, n, lat_of(d) + 1);
        chk({tag, "_busy_resp"}, {31'd0, busy[d]}, 1);
        chk({tag, "_strobes"}, {30'd0, rvalid[d], wdone[d]}, m ? 32'd1 : 32'd2);
        chk({tag, "_err"}, {31'd0, err[d]}, {31'd0, !rng});
        rd = rdata[d];
        if (!m && known) chk({tag, "_rdata"}, rdata[d], exp);
      end else if (!busy[d]) begin
        busy_low++;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_busy_wait"}, busy_low, 0);
    if (m && rng) mdl[k] = wd;
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, {31'd0, busy[d]}, 0);
    if (!m && known) chk({tag, "_rdata_hold"}, rdata[d], exp);
  endtask

  typedef struct {
    int          d;
    bit          m;
    logic [31:0] a;
    logic [31:0] wd;
    bit          ce;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] rd;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; mode[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_rdata%0d", d), rdata[d], 0);
      chk($sformatf("reset_flags%0d", d), {28'd0, rvalid[d], wdone[d], busy[d], err[d]}, 0);
      rst[d] = 1'b0;
    end

    // Directed table: {dut, mode, addr, wdata, check read, expected read}
    vecs.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF});
    vecs.push_back('{1, 1'b1, 32'h04,  32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b0, 32'h04,  32'h0,        1'b1, 32'h12345678});
    vecs.push_back('{0, 1'b1, 32'h13,  32'hA5A5A5A5, 1'b0, 32'h0});
    vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        1'b1, 32'hA5A5A5A5});
    vecs.push_back('{1, 1'b1, 32'h000, 32'h00000077, 1'b0, 32'h0});
    vecs.push_back('{1, 1'b1, 32'h400, 32'h0BADF00D, 1'b0, 32'h0});
`ifdef BUS_RESP_ADDR_CHECK_EN
    vecs.push_back('{1, 1'b0, 32'h000, 32'h0,        1'b1, 32'h00000077});
    vecs.push_back('{1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h00000000});
`else
    vecs.push_back('{1, 1'b0, 32'h000, 32'h0,        1'b1, 32'h0BADF00D});
    vecs.push_back('{1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0BADF00D});
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      txn(vecs[i].d, vecs[i].m, vecs[i].a, vecs[i].wd, $sformatf("vec%0d", i), rd);
      if (vecs[i].ce) chk($sformatf("vec%0d_table", i), rd, vecs[i].exp);
    end

    // Requests during WAIT and RESP of an active write are ignored.
    txn(0, 1'b1, 32'h24, 32'h55AA55AA, "ign_pre", rd);
    begin
      int strobes;
      int at_n;
      strobes = 0;
      at_n    = 0;
      start[0] = 1'b1; mode[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h0000ABCD;
      @(posedge clk); #1;
      addr[0] = 32'h24; wdata[0] = 32'hFFFF0000;
      for (int n = 1; n <= 3; n++) begin
        @(negedge clk);
        if (rvalid[0] || wdone[0]) begin strobes++; at_n = n; end
        if (n == 3) start[0] = 1'b0;
      end
      for (int n = 4; n <= 6; n++) begin
        @(negedge clk);
        if (rvalid[0] || wdone[0]) strobes++;
        if (busy[0]) strobes += 100;
      end
      chk("ign_strobe_count", strobes, 1);
      chk("ign_strobe_cycle", at_n, 3);
      mdl[key(0, 32'h20)] = 32'h0000ABCD;
      @(posedge clk); #1;
      txn(0, 1'b0, 32'h24, 32'h0, "ign_read24", rd);
      chk("ign_read24_val", rd, 32'h55AA55AA);
      txn(0, 1'b0, 32'h20, 32'h0, "ign_read20", rd);
    end

    // Reset in the first WAIT cycle and in the cycle just before RESP.
    for (int rc = 1; rc <= 2; rc++) begin
      int strobes;
      strobes = 0;
      txn(0, 1'b1, 32'h08, 32'h11111111, "abort_pre", rd);
      start[0] = 1'b1; mode[0] = 1'b1; addr[0] = 32'h08; wdata[0] = 32'hCAFEF00D;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (rc - 1) begin @(posedge clk); #1; end
      rst[0] = 1'b1;
      @(negedge clk);
      if (rvalid[0] || wdone[0]) strobes++;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(negedge clk);
      if (rvalid[0] || wdone[0]) strobes++;
      chk($sformatf("abort%0d_busy", rc), {31'd0, busy[0]}, 0);
      chk($sformatf("abort%0d_strobes", rc), strobes, 0);
      @(posedge clk); #1;
      txn(0, 1'b0, 32'h08, 32'h0, $sformatf("abort%0d_read", rc), rd);
      chk($sformatf("abort%0d_data", rc), rd, 32'h11111111);
    end

    // Reset wins over a simultaneous start; start is taken right after release.
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b1; mode[d] = 1'b1; addr[d] = 32'h30; wdata[d] = 32'h99990000;
      @(posedge clk); #1;
      chk($sformatf("rst_prio%0d_busy", d), {31'd0, busy[d]}, 0);
      rst[d] = 1'b0;
      txn(d, 1'b1, 32'h30, 32'h13572468, $sformatf("rst_first%0d", d), rd);
      txn(d, 1'b0, 32'h30, 32'h0, $sformatf("rst_read%0d", d), rd);
      chk($sformatf("rst_read%0d_val", d), rd, 32'h13572468);
    end

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      int          d;
      bit          m;
      logic [31:0] a;
      d = i % 2;
      m = 1'($urandom);
      a = ((($urandom % 4) == 0) ? (32'($urandom_range(1, 3)) << (AW + 2)) : 32'd0)
          | (32'($urandom_range(0, 7)) << 2) | 32'($urandom % 4);
      txn(d, m, a, $urandom, $sformatf("rnd%0d", i), rd);
      repeat ($urandom % 2) begin @(posedge clk); #1; end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, giving wait cycles between accept and response; the legal range is 0..15.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 BUS_start_transaction  input  1  request strobe from the initiator.
REQ-007 BUS_mode  input  1  0 = read, 1 = write; sampled with the start strobe.
REQ-008 BUS_addr  input  32  byte address; sampled with the start strobe.
REQ-009 BUS_wdata  input  32  write data; sampled with the start strobe.
REQ-010 BUS_rdata  output  32  read data; valid while BUS_rdata_valid is high.
REQ-011 BUS_rdata_valid  output  1  one-cycle read-completion strobe.
REQ-012 BUS_write_done  output  1  one-cycle write-completion strobe.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with BUS_start_transaction=1 at edge E, the block SHALL latch mode, addr and wdata and go to WAIT; with LATENCY=0 it SHALL go directly to RESP.
REQ-016 WAIT SHALL last exactly LATENCY cycles, counted by a 4-bit down-counter loaded with LATENCY-1, then go to RESP.
REQ-017 Total latency SHALL be LATENCY+1 cycles: the strobe is high in cycle E+1+LATENCY, where cycle E+1 is the cycle following edge E.
REQ-018 The word index SHALL be BUS_addr[ADDR_W+1:2]; BUS_addr[1:0] SHALL be ignored, with no misalignment handling.
REQ-019 On a write, the memory word SHALL be updated at the edge that enters RESP, and BUS_write_done SHALL be 1 for exactly the RESP cycle.
REQ-020 On a read, BUS_rdata SHALL be registered at the edge that enters RESP, and BUS_rdata_valid SHALL be 1 for exactly the RESP cycle.
REQ-021 BUS_rdata SHALL hold its last value outside RESP and SHALL be 0 after reset.
REQ-022 RESP SHALL always return to IDLE on the next edge.
REQ-023 BUS_start_transaction while busy=1, including during the RESP cycle, SHALL be ignored: it is not queued, not latched, and has no effect.
REQ-024 The earliest accepted back-to-back request SHALL be in the cycle after RESP, so accepted requests are at least LATENCY+2 cycles apart.
REQ-025 BUS_rdata_valid and BUS_write_done SHALL never be high in the same cycle.
REQ-026 A read following a write to the same word SHALL return the written data.
REQ-027 Memory contents SHALL be uninitialised and SHALL not be cleared by reset.

Reset
REQ-028 On any edge with rst=1, the state SHALL be set to IDLE, the counter to 0, and BUS_rdata, BUS_rdata_valid, BUS_write_done and busy to 0.
REQ-029 rst takes priority over BUS_start_transaction in the same cycle.
REQ-030 Reset during WAIT SHALL abort the transaction with no strobe and no memory write.
REQ-031 Reset asserted in the cycle before RESP SHALL also suppress the write, because the write edge is a reset edge.
REQ-032 After rst deasserts, the block SHALL accept a start in the first cycle.

Configuration
REQ-033 Macro BUS_RESP_ADDR_CHECK_EN SHALL control address-range checking.
REQ-034 When BUS_RESP_ADDR_CHECK_EN is defined:
- the block SHALL add output BUS_err (1 bit).
- A request is out of range if any of BUS_addr[31:ADDR_W+2] is nonzero.
- For out-of-range requests, BUS_err=1 with the normal strobe in RESP.
- Out-of-range writes SHALL be suppressed; out-of-range reads SHALL return BUS_rdata=0.
- BUS_err is 0 in all other cycles and after reset.
REQ-035 When BUS_RESP_ADDR_CHECK_EN is not defined:
- BUS_err SHALL not exist.
- Upper address bits SHALL be ignored, so addresses alias modulo 4*2^ADDR_W bytes.

Verification
REQ-036 LATENCY=2: write addr 0x10, data 0xDEADBEEF, start at edge E -> BUS_write_done=1 only in cycle E+3; busy=1 in cycles E+1..E+3.
REQ-037 LATENCY=2: after REQ-036, read addr 0x10 -> BUS_rdata=0xDEADBEEF with BUS_rdata_valid=1 for one cycle, 3 cycles after accept.
REQ-038 LATENCY=0: write 0x12345678 to 0x04, then read 0x04 -> each strobe occurs 1 cycle after its start; read returns 0x12345678.
REQ-039 Start pulsed in the WAIT and RESP cycles of an active write to 0x20 -> only one strobe; the ignored request's write to 0x24 is absent when 0x24 is read back.
REQ-040 rst=1 in the WAIT cycle of a write of 0xCAFEF00D to 0x08 over prior data 0x11111111 -> no strobe, busy=0 the next cycle; reading 0x08 returns 0x11111111.
REQ-041 With the macro and ADDR_W=8: write to 0x400 -> BUS_write_done=1, BUS_err=1; reading 0x000 is unchanged; reading 0x400 gives rdata=0, err=1. Without the macro: reading 0x000 returns the written value.
